// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_bus_timeout.sv
// Transaction age counter: cleared when a transaction starts, flags the last allowed cycle.
module bus_timeout
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and data (D) masters.
// state   | meaning
// IDLE    | no transaction; pick an owner and latch its request bundle
// REQ     | m_req driven with latched bundle, waiting for m_gnt
// WAIT    | accepted, waiting for m_rvalid (or timeout abort)
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        m_req,
   output logic        m_we,
   output logic [3:0]  m_be,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata
);

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d, last_q, last_d, pick;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic        any_req, tmo_clr, tmo_en, tmo_expired;
   logic        done, abort, gnt_w, rv_w;
   logic [31:0] rdata_w;

   assign any_req = i_req | d_req;
   assign tmo_clr = (state_q == ST_IDLE) && any_req;
   assign tmo_en  = (state_q != ST_IDLE);
   assign done    = (state_q == ST_WAIT) && m_rvalid;
   // A response landing on the last allowed cycle wins over the abort.
   assign abort   = tmo_en && tmo_expired && !done;

   bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst_n   (rst),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   always_comb begin
      pick = OWN_I;
      if (i_req && d_req) begin
         pick = (last_q == OWN_I) ? OWN_D : OWN_I;
      end else if (d_req) begin
         pick = OWN_D;
      end

      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_REQ;
               owner_d = pick;
               last_d  = pick;
               if (pick == OWN_D) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  be_d    = d_be;
                  wdata_d = d_wdata;
               end else begin
                  addr_d  = i_addr;
                  we_d    = 1'b0;
                  be_d    = 4'hF;
                  wdata_d = '0;
               end
            end
         end
         ST_REQ: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (m_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done || abort) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_I;
         last_q  <= OWN_I;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
      end
   end

   assign m_req   = (state_q == ST_REQ) && !abort;
   assign m_addr  = addr_q;
   assign m_we    = we_q;
   assign m_be    = be_q;
   assign m_wdata = wdata_q;

   assign gnt_w   = m_req && m_gnt;
   assign rv_w    = done || abort;
   assign rdata_w = done ? m_rdata : '0;

   assign i_gnt    = gnt_w && (owner_q == OWN_I);
   assign i_rvalid = rv_w  && (owner_q == OWN_I);
   assign i_err    = abort && (owner_q == OWN_I);
   assign i_rdata  = (owner_q == OWN_I) ? rdata_w : '0;
   assign d_gnt    = gnt_w && (owner_q == OWN_D);
   assign d_rvalid = rv_w  && (owner_q == OWN_D);
   assign d_err    = abort && (owner_q == OWN_D);
   assign d_rdata  = (owner_q == OWN_D) ? rdata_w : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level bench for mem_arbiter: bench plays both masters and the memory.
module tb_mem_arbiter;

   localparam int TMO = 8;

   logic        clk, rst;
   logic        i_req, i_gnt, i_rvalid, i_err;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [3:0]  d_be;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_req, m_we, m_gnt, m_rvalid;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_rdata;

   int checks = 0;
   int errors = 0;

   // Pending request state of each master, and who was served last (1 = D).
   logic        i_pend, d_pend, pd_we;
   logic [31:0] pi_addr, pd_addr, pd_wdata;
   logic [3:0]  pd_be;
   bit          last_d;

   mem_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic exp_out(input bit own_d, input bit g, input bit rv, input bit er,
                          input logic [31:0] rd, input bit mreq);
      chk1 ("i_gnt",    i_gnt,    !own_d && g);
      chk1 ("d_gnt",    d_gnt,     own_d && g);
      chk1 ("i_rvalid", i_rvalid, !own_d && rv);
      chk1 ("d_rvalid", d_rvalid,  own_d && rv);
      chk1 ("i_err",    i_err,    !own_d && er);
      chk1 ("d_err",    d_err,     own_d && er);
      chk32("i_rdata",  i_rdata,  own_d ? 32'h0 : rd);
      chk32("d_rdata",  d_rdata,  own_d ? rd : 32'h0);
      chk1 ("m_req",    m_req,    mreq);
   endtask

   task automatic drive();
      i_req   = i_pend;
      i_addr  = pi_addr;
      d_req   = d_pend;
      d_we    = pd_we;
      d_be    = pd_be;
      d_addr  = pd_addr;
      d_wdata = pd_wdata;
   endtask

   // One whole transaction: IDLE selection cycle, REQ phase, WAIT phase.
   task automatic run_txn(input bit new_i, input bit new_d, input int gnt_dly,
                          input int rv_dly, input logic [31:0] rd_val);
      bit          own_d, granted, done, rv;
      int          t, k;
      logic [31:0] e_addr;
      logic        e_we;
      logic [3:0]  e_be;
      if (new_i && !i_pend) begin i_pend = 1'b1; pi_addr = $urandom; end
      if (new_d && !d_pend) begin
         d_pend = 1'b1; pd_addr = $urandom; pd_we = 1'($urandom);
         pd_be = 4'($urandom); pd_wdata = $urandom;
      end
      if (!i_pend && !d_pend) begin i_pend = 1'b1; pi_addr = $urandom; end
      own_d  = (i_pend && d_pend) ? !last_d : d_pend;
      last_d = own_d;
      e_addr = own_d ? pd_addr : pi_addr;
      e_we   = own_d ? pd_we : 1'b0;
      e_be   = own_d ? pd_be : 4'hF;

      @(negedge clk); drive(); m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = $urandom; #1;
      exp_out(own_d, 0, 0, 0, 32'h0, 0);

      t = 0; k = 0; granted = 0; done = 0;
      while (!done && !granted) begin
         t++;
         @(negedge clk); drive();
         m_gnt = (k == gnt_dly); m_rvalid = 1'($urandom); m_rdata = $urandom; #1;
         if (t == TMO) begin
            exp_out(own_d, 0, 1, 1, 32'h0, 0);
            done = 1;
         end else begin
            exp_out(own_d, m_gnt, 0, 0, 32'h0, 1);
            chk32("m_addr", m_addr, e_addr);
            chk1 ("m_we",   m_we,   e_we);
            chk32("m_be",   {28'h0, m_be}, {28'h0, e_be});
            if (own_d) chk32("m_wdata", m_wdata, pd_wdata);
            granted = m_gnt;
         end
         k++;
      end
      if (granted) begin
         if (own_d) d_pend = 1'b0; else i_pend = 1'b0;
      end
      k = 0;
      while (!done) begin
         t++;
         rv = (k == rv_dly);
         @(negedge clk); drive();
         m_gnt = 1'($urandom); m_rvalid = rv; m_rdata = rv ? rd_val : $urandom; #1;
         if (rv) begin
            exp_out(own_d, 0, 1, 0, rd_val, 0);
            done = 1;
         end else if (t == TMO) begin
            exp_out(own_d, 0, 1, 1, 32'h0, 0);
            done = 1;
         end else begin
            exp_out(own_d, 0, 0, 0, 32'h0, 0);
         end
         k++;
      end
      if (own_d) d_pend = 1'b0; else i_pend = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      i_pend = 0; d_pend = 0; pi_addr = 0; pd_addr = 0; pd_wdata = 0; pd_we = 0; pd_be = 0;
      last_d = 0;
      drive();
      m_gnt = 0; m_rvalid = 0; m_rdata = 0;
      repeat (2) @(negedge clk);
      #1;
      exp_out(0, 0, 0, 0, 32'h0, 0);
      chk32("rst_m_addr", m_addr, 32'h0);
      chk1 ("rst_m_we",   m_we,   1'b0);
      chk32("rst_m_be",   {28'h0, m_be}, 32'h0);
      chk32("rst_m_wdata", m_wdata, 32'h0);
      @(negedge clk); rst = 1'b1;

      // First tie after reset goes to D, then I, then D again.
      i_pend = 1; pi_addr = 32'h0000_0400;
      d_pend = 1; pd_addr = 32'h0000_0800; pd_we = 1; pd_be = 4'b0011; pd_wdata = 32'hDEAD_BEEF;
      run_txn(0, 0, 0, 0, $urandom);
      run_txn(0, 0, 0, 0, $urandom);
      run_txn(1, 1, 0, 0, $urandom);
      run_txn(0, 0, 0, 0, $urandom);

      // Minimum-latency fetch.
      i_pend = 1; pi_addr = 32'h0000_0010;
      run_txn(0, 0, 0, 0, 32'h0000_0013);

      // Grant stalled 5 cycles, then completion exactly on the timeout cycle.
      run_txn(0, 1, 5, 0, $urandom);
      run_txn(1, 0, 3, 3, $urandom);

      // Memory never responds: aborts in WAIT and in REQ.
      run_txn(0, 1, 1, 99, $urandom);
      run_txn(0, 1, 99, 0, $urandom);
      run_txn(1, 0, 99, 0, $urandom);

      for (int n = 0; n < 40; n++) begin
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom);
      end

      // Reset while waiting for the response.
      i_pend = 1; d_pend = 0; pi_addr = 32'hCAFE_0000;
      @(negedge clk); drive(); m_gnt = 0; m_rvalid = 0; #1;
      @(negedge clk); m_gnt = 1; #1;
      chk1("rw_i_gnt", i_gnt, 1'b1);
      i_pend = 0;
      @(negedge clk); drive(); m_gnt = 0; m_rvalid = 0; #1;
      chk1("rw_wait_rvalid", i_rvalid, 1'b0);
      m_rvalid = 1; m_rdata = 32'h1234_5678; rst = 1'b0; #1;
      exp_out(0, 0, 0, 0, 32'h0, 0);
      chk32("rw_m_addr", m_addr, 32'h0);
      @(negedge clk); #1;
      exp_out(0, 0, 0, 0, 32'h0, 0);
      rst = 1'b1; m_rvalid = 0; last_d = 0;
      run_txn(1, 0, 0, 0, $urandom);
      run_txn(1, 1, 1, 1, $urandom);
      run_txn(0, 0, 0, 0, $urandom);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the cycles a transaction may stay in REQ+WAIT before abort (range 2..65535).
REQ-002 SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-003 SHALL have port rst  input  1  meaning the reset, asynchronous, active-low.
REQ-004 SHALL have port i_req  input  1  meaning instruction-fetch request, held until i_gnt.
REQ-005 SHALL have port i_addr  input  32  meaning fetch address.
REQ-006 SHALL have port i_gnt  output  1  meaning fetch accepted by memory.
REQ-007 SHALL have port i_rvalid  output  1  meaning fetch data/abort valid, one cycle.
REQ-008 SHALL have port i_rdata  output  32  meaning fetched instruction.
REQ-009 SHALL have port i_err  output  1  meaning fetch aborted by timeout, qualified by i_rvalid.
REQ-010 SHALL have port d_req  input  1  meaning data load/store request, held until d_gnt.
REQ-011 SHALL have port d_we  input  1  meaning 1 = store, 0 = load.
REQ-012 SHALL have port d_be  input  4  meaning store byte enables.
REQ-013 SHALL have port d_addr  input  32  meaning data address.
REQ-014 SHALL have port d_wdata  input  32  meaning store data.
REQ-015 SHALL have port d_gnt  output  1  meaning data request accepted by memory.
REQ-016 SHALL have port d_rvalid  output  1  meaning load data or store ack valid, one cycle.
REQ-017 SHALL have port d_rdata  output  32  meaning load data.
REQ-018 SHALL have port d_err  output  1  meaning data access aborted by timeout, qualified by d_rvalid.
REQ-019 SHALL have ports m_req/m_we/m_be/m_addr/m_wdata  output  1/1/4/32/32  meaning the shared memory request bundle.
REQ-020 SHALL have ports m_gnt/m_rvalid/m_rdata  input  1/1/32  meaning memory accept, response strobe, and read data.

Function
REQ-021 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE, with at most one outstanding memory transaction.
REQ-022 In IDLE, any requester active: SHALL select an owner, register its address, we, be and wdata (I: we=0, be=4'hF), and enter REQ on the next edge.
REQ-023 Both requesters active in IDLE: SHALL grant the requester not served last (round-robin); after reset D wins the first tie.
REQ-024 In REQ: SHALL drive m_req=1 with the registered bundle; owner gnt = m_gnt combinationally; m_gnt=1 SHALL move the FSM to WAIT.
REQ-025 m_req, m_addr, m_we, m_be and m_wdata SHALL stay stable in REQ until m_gnt; m_req=0 outside REQ.
REQ-026 In WAIT: owner rvalid = m_rvalid and owner rdata = m_rdata, err=0; m_rvalid=1 SHALL return the FSM to IDLE.
REQ-027 Minimum latency SHALL be: request sampled at cycle 0, m_req at cycle 1, gnt at cycle 1, rvalid at cycle 2.
REQ-028 The non-owner's gnt/rvalid/err SHALL be 0 and its rdata 0; m_rvalid outside WAIT SHALL be ignored.
REQ-029 A timeout counter SHALL clear on IDLE->REQ and increment each cycle in REQ/WAIT.
REQ-030 Counter reaching TIMEOUT-1 with no completion: owner rvalid=1, err=1, rdata=0 for that cycle, m_req=0, FSM to IDLE.
REQ-031 Completion and timeout in the same cycle: completion SHALL take precedence (err=0, real data).
REQ-032 A requester dropping req before gnt SHALL be treated as a protocol violation; the arbiter SHALL still complete the latched transaction.

Reset
REQ-033 rst=0 SHALL immediately force IDLE: counter=0, last-served=I, all outputs 0 including m_req; any in-flight transaction is abandoned and no rvalid is issued for it.

Structure
REQ-034 The package SHALL hold the FSM state enum, the owner enum {OWN_I, OWN_D}, and the default TIMEOUT constant.
REQ-035 One sub-module, bus_timeout (load/clear, enable, expired flag), SHALL implement the counter.

Verification
REQ-036 Lone i_req, addr 0x0000_0010, m_gnt same cycle, m_rvalid next cycle with data 0x0000_0013 -> i_gnt at cycle 1, i_rvalid at cycle 2, i_rdata=0x0000_0013, i_err=0.
REQ-037 i_req and d_req together after reset -> D served first (store, be=4'b0011, wdata 0xDEAD_BEEF on m_*), then I; next tie serves D again.
REQ-038 m_gnt held low 5 cycles -> m_req and bundle stable all 5 cycles; d_gnt only on the cycle m_gnt=1.
REQ-039 TIMEOUT=8, memory never responds -> d_rvalid=1, d_err=1, d_rdata=0 exactly 8 cycles after REQ entry; a late m_rvalid is ignored.
REQ-040 rst asserted in WAIT -> all outputs 0 immediately; after release a new i_req completes normally.
